// File: rtl/cube_pkg.sv
// Shared constants and types for the cube overlay frame controller.
package cube_pkg;

  localparam int unsigned MAX_X          = 1226;
  localparam int unsigned MAX_Y          = 370;
  localparam int unsigned CORD_SIZE      = 11;
  localparam int unsigned N_CORNERS      = 8;
  localparam int unsigned CORNER_W       = 32;
  localparam int unsigned CORNER_X_LSB   = 0;
  localparam int unsigned CORNER_Y_LSB   = 16;
  localparam int unsigned CORNER_FIELD_W = 11;

  typedef logic [N_CORNERS-1:0][CORNER_W-1:0] cube_pts_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ARMED = 2'd1,
    LIVE  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/cube_frame_ctrl_raster_tracker.sv
// Raster position tracker fed by the overlay input AXIS handshake tap.
// Flags tlast mismatches and resyncs to the next line on an early tlast.
module raster_tracker #(
  parameter int unsigned MAX_X     = cube_pkg::MAX_X,
  parameter int unsigned MAX_Y     = cube_pkg::MAX_Y,
  parameter int unsigned CORD_SIZE = cube_pkg::CORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic [CORD_SIZE-1:0] cur_x,
  output logic [CORD_SIZE-1:0] cur_y,
  output logic                 px_c,
  output logic                 eof_c,
  output logic                 mismatch_c
);

  localparam logic [CORD_SIZE-1:0] LAST_X = CORD_SIZE'(MAX_X - 1);
  localparam logic [CORD_SIZE-1:0] LAST_Y = CORD_SIZE'(MAX_Y - 1);

  logic eol_c;
  logic line_end_c;

  // An early tlast ends the line just like the natural end of line does.
  assign px_c       = mon_tvalid & mon_tready;
  assign eol_c      = (cur_x == LAST_X);
  assign line_end_c = eol_c | mon_tlast;
  assign eof_c      = line_end_c & (cur_y == LAST_Y);
  assign mismatch_c = px_c & (mon_tlast ^ eol_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (px_c) begin
      if (line_end_c) begin
        cur_x <= '0;
        cur_y <= (cur_y == LAST_Y) ? '0 : cur_y + CORD_SIZE'(1);
      end else begin
        cur_x <= cur_x + CORD_SIZE'(1);
      end
    end
  end

endmodule

// File: rtl/cube_frame_ctrl.sv
// Cube overlay sequencer: shadow-buffers pose updates and commits them only
// at frame boundaries; disables the overlay when the pose goes stale.
module cube_frame_ctrl #(
  parameter int unsigned MAX_X        = cube_pkg::MAX_X,
  parameter int unsigned MAX_Y        = cube_pkg::MAX_Y,
  parameter int unsigned CORD_SIZE    = cube_pkg::CORD_SIZE,
  parameter int unsigned STALE_FRAMES = 4,
  parameter int unsigned FCNT_W       = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  input  logic                 upd_valid,
  input  cube_pkg::cube_pts_t  upd_pts,
  output logic                 upd_ready,
  input  logic                 ovl_clear,
  output cube_pkg::cube_pts_t  cube_pts,
  output logic                 overlay_en,
  output logic [CORD_SIZE-1:0] cur_x,
  output logic [CORD_SIZE-1:0] cur_y,
  output logic [FCNT_W-1:0]    frame_cnt,
  output logic                 line_err
);
  import cube_pkg::*;

  localparam int unsigned STALE_W = $clog2(STALE_FRAMES + 1);

  ctrl_state_t          state_q, state_d;
  logic                 ready_q, ready_d;
  cube_pts_t            shadow_q, shadow_d;
  cube_pts_t            cube_d;
  logic                 en_d;
  logic [STALE_W-1:0]   stale_q, stale_d;
  logic [FCNT_W-1:0]    fcnt_d;
  logic                 err_d;
  logic                 px_c, eof_c, mismatch_c, eof_px_c;
  logic                 accept_c, shadow_full_c, commit_c;

  raster_tracker #(
    .MAX_X     (MAX_X),
    .MAX_Y     (MAX_Y),
    .CORD_SIZE (CORD_SIZE)
  ) u_raster (
    .clk        (s00_axis_aclk),
    .rst_n      (s00_axis_aresetn),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .mon_tlast  (mon_tlast),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .px_c       (px_c),
    .eof_c      (eof_c),
    .mismatch_c (mismatch_c)
  );

  // Ready is a register; a clear pulse blocks acceptance in its own cycle.
  assign upd_ready     = ready_q & ~ovl_clear;
  assign accept_c      = upd_valid & upd_ready;
  assign shadow_full_c = ~ready_q;
  assign eof_px_c      = px_c & eof_c;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    shadow_d = shadow_q;
    cube_d   = cube_pts;
    en_d     = overlay_en;
    stale_d  = stale_q;
    err_d    = line_err | mismatch_c;
    fcnt_d   = eof_px_c ? frame_cnt + FCNT_W'(1) : frame_cnt;
    commit_c = 1'b0;

    unique case (state_q)
      EMPTY: if (accept_c) state_d = ARMED;
      ARMED: if (eof_px_c && shadow_full_c) commit_c = 1'b1;
      LIVE: begin
        if (eof_px_c) begin
          if (shadow_full_c) begin
            commit_c = 1'b1;
          end else if (stale_q == STALE_W'(STALE_FRAMES - 1)) begin
            en_d    = 1'b0;
            stale_d = '0;
            state_d = accept_c ? ARMED : EMPTY;
          end else begin
            stale_d = stale_q + STALE_W'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    // Commit moves the prior shadow contents; a same-cycle accept refills it.
    if (commit_c) begin
      cube_d  = shadow_q;
      ready_d = 1'b1;
      stale_d = '0;
      en_d    = 1'b1;
      state_d = LIVE;
    end
    if (accept_c) begin
      shadow_d = upd_pts;
      ready_d  = 1'b0;
    end

    if (ovl_clear) begin
      state_d = EMPTY;
      en_d    = 1'b0;
      ready_d = 1'b1;
      err_d   = 1'b0;
      stale_d = '0;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q    <= EMPTY;
      ready_q    <= 1'b1;
      shadow_q   <= '0;
      cube_pts   <= '0;
      overlay_en <= 1'b0;
      stale_q    <= '0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      shadow_q   <= shadow_d;
      cube_pts   <= cube_d;
      overlay_en <= en_d;
      stale_q    <= stale_d;
      frame_cnt  <= fcnt_d;
      line_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_cube_frame_ctrl.sv
// Self-checking bench for cube_frame_ctrl: vector table, directed frame
// sequences and randomized traffic against a behavioural model.
module tb_cube_frame_ctrl;
  import cube_pkg::*;

  localparam int unsigned TMX      = 128;
  localparam int unsigned TMY      = 8;
  localparam int unsigned TSTALE   = 4;
  localparam int unsigned TCS      = 11;
  localparam int unsigned TFW      = 16;
  localparam int unsigned FRAME_PX = TMX * TMY;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mon_tvalid, mon_tready, mon_tlast;
  logic           upd_valid, ovl_clear;
  logic [255:0]   upd_pts;
  logic           upd_ready;
  logic [255:0]   cube_pts;
  logic           overlay_en;
  logic [TCS-1:0] cur_x, cur_y;
  logic [TFW-1:0] frame_cnt;
  logic           line_err;

  int n_pass = 0;
  int n_checks = 0;

  // Behavioural model state
  int unsigned  mx, my, m_stale, m_fcnt;
  logic [255:0] m_cube, m_shadow;
  bit           m_sv, m_en, m_err;

  cube_frame_ctrl #(
    .MAX_X(TMX), .MAX_Y(TMY), .CORD_SIZE(TCS), .STALE_FRAMES(TSTALE), .FCNT_W(TFW)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .mon_tvalid       (mon_tvalid),
    .mon_tready       (mon_tready),
    .mon_tlast        (mon_tlast),
    .upd_valid        (upd_valid),
    .upd_pts          (upd_pts),
    .upd_ready        (upd_ready),
    .ovl_clear        (ovl_clear),
    .cube_pts         (cube_pts),
    .overlay_en       (overlay_en),
    .cur_x            (cur_x),
    .cur_y            (cur_y),
    .frame_cnt        (frame_cnt),
    .line_err         (line_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [319:0] dut_obs();
    return 320'({cube_pts, overlay_en, upd_ready, cur_x, cur_y, frame_cnt, line_err});
  endfunction

  function automatic logic [319:0] model_obs(input bit clr);
    logic rdy;
    rdy = !m_sv && !clr;
    return 320'({m_cube, m_en, rdy, TCS'(mx), TCS'(my), TFW'(m_fcnt), m_err});
  endfunction

  function automatic logic [255:0] make_set(input int unsigned base);
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i*32 + CORNER_X_LSB +: 11] = 11'(base + i);
      s[i*32 + CORNER_Y_LSB +: 11] = 11'(base + i);
    end
    return s;
  endfunction

  function automatic bit eol_now();
    return mx == TMX - 1;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; m_stale = 0; m_fcnt = 0;
    m_cube = '0; m_shadow = '0; m_sv = 0; m_en = 0; m_err = 0;
  endtask

  // One clock of the reference behaviour, from the raster and frame rules.
  task automatic model_update(input bit tv, tr, tl, uv, input logic [255:0] pts, input bit clr);
    bit px, eol, lend, eof, mis, acc;
    px   = tv && tr;
    eol  = (mx == TMX - 1);
    lend = px && (tl || eol);
    eof  = lend && (my == TMY - 1);
    mis  = px && (tl != eol);
    acc  = uv && !m_sv && !clr;
    if (px) begin
      if (lend) begin
        mx = 0;
        my = eof ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    if (eof) m_fcnt = m_fcnt + 1;
    if (clr) begin
      m_sv = 0; m_en = 0; m_err = 0; m_stale = 0;
    end else begin
      if (mis) m_err = 1;
      if (eof) begin
        if (m_sv) begin
          m_cube = m_shadow; m_en = 1; m_stale = 0; m_sv = 0;
        end else if (m_en) begin
          m_stale = m_stale + 1;
          if (m_stale == TSTALE) begin
            m_en = 0; m_stale = 0;
          end
        end
      end
      if (acc) begin
        m_shadow = pts; m_sv = 1;
      end
    end
  endtask

  task automatic step(input bit tv, tr, tl, uv, input logic [255:0] pts, input bit clr);
    mon_tvalid = tv; mon_tready = tr; mon_tlast = tl;
    upd_valid = uv; upd_pts = pts; ovl_clear = clr;
    @(posedge clk);
    model_update(tv, tr, tl, uv, pts, clr);
    #1;
    chk("cycle", dut_obs(), model_obs(clr));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    upd_valid = 0; upd_pts = '0; ovl_clear = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", dut_obs(), model_obs(1'b0));
    rst_n = 1'b1;
  endtask

  task automatic px_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b1, eol_now(), 1'b0, '0, 1'b0);
  endtask

  task automatic run_to(input int unsigned x, input int unsigned y);
    int unsigned guard;
    guard = 0;
    while (!(mx == x && my == y) && guard < 2 * FRAME_PX) begin
      step(1'b1, 1'b1, eol_now(), 1'b0, '0, 1'b0);
      guard++;
    end
    chk("run_to_pos", 320'({cur_x, cur_y}), 320'({TCS'(x), TCS'(y)}));
  endtask

  typedef struct {
    bit tv, tr, tl, clr;
    int unsigned ex, ey;
    bit eerr;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [255:0] set_a, set_b, set_c, set_d, set_e, set_f, set_g, set_h, rp;
    logic [TFW-1:0] f0;
    int unsigned npx, npx_at_eof;
    bit done, tv, tr, tl, uv, clr;

    set_a = make_set(0);  set_b = make_set(16); set_c = make_set(32);
    set_d = make_set(48); set_e = make_set(64); set_f = make_set(80);
    set_g = make_set(96); set_h = make_set(112);

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].tv, tbl[i].tr, tbl[i].tl, 1'b0, '0, tbl[i].clr);
      chk($sformatf("tbl%0d", i), 320'({cur_x, cur_y, line_err}),
          320'({TCS'(tbl[i].ex), TCS'(tbl[i].ey), tbl[i].eerr}));
    end

    // First commit after reset
    do_reset();
    px_n(300);
    step(1'b1, 1'b1, eol_now(), 1'b1, set_a, 1'b0);
    chk("armed_ready", 320'(upd_ready), 320'(1'b0));
    run_to(TMX - 1, TMY - 1);
    chk("pre_eof_en", 320'(overlay_en), 320'(1'b0));
    chk("pre_eof_cube", 320'(cube_pts), 320'(0));
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("commit_cube", 320'(cube_pts), 320'(set_a));
    chk("commit_en", 320'(overlay_en), 320'(1'b1));
    chk("frame_cnt1", 320'(frame_cnt), 320'(1));
    chk("commit_ready", 320'(upd_ready), 320'(1'b1));

    // Second update mid-frame while LIVE
    run_to(10, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1, set_b, 1'b0);
    chk("upd2_ready", 320'(upd_ready), 320'(1'b0));
    run_to(TMX - 1, TMY - 1);
    chk("upd2_old_held", 320'(cube_pts), 320'(set_a));
    chk("upd2_ready_eof", 320'(upd_ready), 320'(1'b0));
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("upd2_commit", 320'(cube_pts), 320'(set_b));
    chk("frame_cnt2", 320'(frame_cnt), 320'(2));

    // Pose goes stale
    for (int f = 1; f <= int'(TSTALE); f++) begin
      run_to(TMX - 1, TMY - 1);
      step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      chk($sformatf("stale_en_f%0d", f), 320'(overlay_en), 320'(f < int'(TSTALE)));
    end
    chk("stale_cube_kept", 320'(cube_pts), 320'(set_b));
    chk("stale_ready", 320'(upd_ready), 320'(1'b1));

    // Early tlast, then clear
    step(1'b0, 1'b0, 1'b0, 1'b1, set_c, 1'b0);
    run_to(TMX - 1, TMY - 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("c_commit", 320'(cube_pts), 320'(set_c));
    run_to(100, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("early_tlast", 320'({line_err, cur_x, cur_y}), 320'({1'b1, TCS'(0), TCS'(4)}));
    step(1'b0, 1'b0, 1'b0, 1'b1, set_d, 1'b0);
    chk("d_ready", 320'(upd_ready), 320'(1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, set_e, 1'b1);
    chk("clear_err_en", 320'({line_err, overlay_en}), 320'(2'b00));
    chk("clear_cube_kept", 320'(cube_pts), 320'(set_c));
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("clear_ready", 320'(upd_ready), 320'(1'b1));

    // Accept in the eof cycle with an empty shadow
    step(1'b0, 1'b0, 1'b0, 1'b1, set_e, 1'b0);
    run_to(TMX - 1, TMY - 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("e_commit", 320'(cube_pts), 320'(set_e));
    run_to(TMX - 1, TMY - 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, set_f, 1'b0);
    chk("same_cycle_no_commit", 320'(cube_pts), 320'(set_e));
    chk("same_cycle_ready", 320'(upd_ready), 320'(1'b0));
    run_to(TMX - 1, TMY - 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("f_commit", 320'(cube_pts), 320'(set_f));

    // Update offered across eof with a full shadow
    px_n(5);
    step(1'b0, 1'b0, 1'b0, 1'b1, set_g, 1'b0);
    run_to(TMX - 1, TMY - 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, set_h, 1'b0);
    chk("g_commit", 320'(cube_pts), 320'(set_g));
    chk("g_ready_freed", 320'(upd_ready), 320'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1, set_h, 1'b0);
    chk("h_held_ready", 320'(upd_ready), 320'(1'b0));
    run_to(TMX - 1, TMY - 1);
    chk("h_not_yet", 320'(cube_pts), 320'(set_g));
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("h_commit", 320'(cube_pts), 320'(set_h));

    // Stalled stream: only handshakes advance
    f0 = frame_cnt;
    npx = 0; npx_at_eof = 0; done = 0;
    for (int unsigned i = 0; i < 4 * FRAME_PX && !done; i++) begin
      tv = ($urandom_range(0, 3) != 0);
      tr = ($urandom_range(0, 1) != 0);
      step(tv, tr, eol_now(), 1'b0, '0, 1'b0);
      if (tv && tr) npx++;
      if (frame_cnt != f0) begin
        done = 1;
        npx_at_eof = npx;
      end
    end
    chk("stall_eof_px", 320'(npx_at_eof), 320'(FRAME_PX));

    // Randomized traffic with a mid-frame reset
    for (int i = 0; i < 20000; i++) begin
      if (i == 9000) do_reset();
      tv  = ($urandom_range(0, 3) != 0);
      tr  = ($urandom_range(0, 3) != 0);
      tl  = eol_now() ^ ($urandom_range(0, 49) == 0);
      uv  = ($urandom_range(0, 4) == 0);
      clr = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 8; k++) rp[k*32 +: 32] = $urandom();
      step(tv, tr, tl, uv, rp, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
